level_set_mux: RTL and testbench
================================

# level_set_mux

Registered, parametrised selector that routes one of NUM_LEVELS per-level object sets to the drawing pipeline. Each set holds NUM_OBJ objects, each with geometry, colour and enable. Level changes are requested through a valid/ready handshake and applied only on frame boundaries, with an optional blanking interval. The block sits between the per-level object ROMs/registers and the object drawers/collision logic.

## Interface
- NUM_LEVELS, 4: number of selectable object sets (≥2)
- NUM_OBJ, 8: objects per set
- COORD_W, 11: width of X/Y/width/height fields
- COLOR_W, 8: colour width
- BLANK_FRAMES, 2: frames of forced-off enables during a switch (≥1)
- LW: localparam, $clog2(NUM_LEVELS)
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse at frame start
- levelCode  in  LW  requested level
- levelReqValid  in  1  request strobe
- levelReqReady  out  1  high only in ACTIVE
- topLeftX_in, topLeftY_in, width_in, height_in  in  NUM_LEVELS*NUM_OBJ*COORD_W  flattened; level-major, object-minor
- color_in  in  NUM_LEVELS*NUM_OBJ*COLOR_W  flattened, same ordering
- enable_in  in  NUM_LEVELS*NUM_OBJ  flattened, same ordering
- topLeftX_out, topLeftY_out, width_out, height_out  out  NUM_OBJ*COORD_W  selected geometry
- color_out  out  NUM_OBJ*COLOR_W  selected colours
- enable_out  out  NUM_OBJ  selected enables, gated during blanking
- activeLevel  out  LW  level currently driving outputs
- switching  out  1  high in PENDING and BLANK
- switchDone  out  1  one-cycle pulse when a switch completes
- badCode  out  1  one-cycle pulse when a request carries levelCode ≥ NUM_LEVELS

## Operation
- States: ACTIVE, PENDING, BLANK.
- ACTIVE: every cycle, outputs load the slice for activeLevel.
- A request is accepted when levelReqValid && levelReqReady.
  - levelCode ≥ NUM_LEVELS: request dropped; badCode pulses; state and activeLevel unchanged (the current level is sticky).
  - levelCode == activeLevel: no switch; switchDone pulses next cycle; stays ACTIVE.
  - Otherwise: nextLevel latched; go to PENDING.
- PENDING: outputs keep tracking the old level. On startOfFrame, go to BLANK with frameCnt = 0.
- BLANK:
  - enable_out forced to 0.
  - Other outputs hold the old level's values.
  - Each startOfFrame increments frameCnt.
  - At the startOfFrame on which frameCnt reaches BLANK_FRAMES: activeLevel ← nextLevel, outputs load the new slice, switchDone pulses, go to ACTIVE.
- Requests are not accepted while switching; levelReqValid is ignored and need not be held.
- startOfFrame coincident with acceptance: acceptance wins; the boundary is not counted; PENDING waits for the next pulse.
- Reset mid-switch: returns to ACTIVE at level 0; the pending request is lost.

## Timing
- Reset values:
  - all data outputs 0, enable_out 0
  - activeLevel 0, state ACTIVE
  - levelReqReady 1, switching 0, switchDone 0, badCode 0
- First rising edge after reset release loads the level-0 slice.
- Data latency is 1 cycle from any *_in change to *_out in ACTIVE.
- switchDone, badCode and activeLevel are registered; they update on the same edge as the new outputs.
- With the feature enabled, total switch latency is (BLANK_FRAMES+1) startOfFrame pulses after acceptance.

## Configuration
- LEVEL_MUX_BLANK_EN defined: behaviour as above, including the BLANK state.
- Undefined: the BLANK state and frame counter are not built. On the first startOfFrame in PENDING, activeLevel updates, the new slice loads, and switchDone pulses. Switch latency is 1 startOfFrame. enable_out is never gated.

## Structure
- Package level_mux_pkg holds:
  - state enum lm_state_t (ACTIVE, PENDING, BLANK)
  - default width constants
  - slice-index helper functions
- Sub-module level_slice_sel: purely combinational; extracts one level's NUM_OBJ fields from the flattened inputs given a level index. The top instantiates it once for the output-load path.

## Test plan
- Reset, hold 3 cycles, release with distinct per-level patterns → outputs 0 during reset; level-0 slice one cycle after release; activeLevel=0.
- Request level 2 mid-frame (NUM_LEVELS=4, BLANK_FRAMES=2) → ready drops; enable_out=0 from the next startOfFrame for 2 frames; level-2 slice and switchDone on the 3rd startOfFrame.
- Request levelCode=3 with NUM_LEVELS=3 → badCode pulse; outputs and activeLevel unchanged; ready stays 1.
- Request the current level → switchDone next cycle; no blanking; enable_out never drops.
- Request coincident with startOfFrame, then pulse levelReqValid again during PENDING → the first pulse is not counted; the second request is ignored; the switch completes per the first request.
- Assert resetN during BLANK → immediate return to zero outputs; level 0 after release; no switchDone.
- Build without LEVEL_MUX_BLANK_EN: request level 1 → switch on the first startOfFrame; enable_out never gated.

Source files
------------

// File: rtl/level_mux_pkg.sv
// Shared types, default widths and slice-index helpers for the level set mux.
// Optional blanking interval is enabled by defining LEVEL_MUX_BLANK_EN.
package level_mux_pkg;

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } lm_state_t;

    localparam int unsigned DEF_NUM_LEVELS   = 4;
    localparam int unsigned DEF_NUM_OBJ      = 8;
    localparam int unsigned DEF_COORD_W      = 11;
    localparam int unsigned DEF_COLOR_W      = 8;
    localparam int unsigned DEF_BLANK_FRAMES = 2;

    // Flattened buses are level-major, object-minor.
    function automatic int unsigned lm_obj_index(input int unsigned level,
                                                 input int unsigned obj,
                                                 input int unsigned num_obj);
        return level * num_obj + obj;
    endfunction

    // Bit offset of field number idx in a bus of w-bit fields.
    function automatic int unsigned lm_field_base(input int unsigned idx,
                                                  input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/level_slice_sel.sv
// Combinational extraction of one level's object fields from the flattened
// per-level buses.
module level_slice_sel
    import level_mux_pkg::*;
#(
    parameter int unsigned  NUM_LEVELS = DEF_NUM_LEVELS,
    parameter int unsigned  NUM_OBJ    = DEF_NUM_OBJ,
    parameter int unsigned  COORD_W    = DEF_COORD_W,
    parameter int unsigned  COLOR_W    = DEF_COLOR_W,
    localparam int unsigned LW         = $clog2(NUM_LEVELS)
) (
    input  logic [LW-1:0]                         level,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] topLeftX_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] topLeftY_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] width_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] height_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COLOR_W-1:0] color_in,
    input  logic [NUM_LEVELS*NUM_OBJ-1:0]         enable_in,
    output logic [NUM_OBJ*COORD_W-1:0]            topLeftX_sel,
    output logic [NUM_OBJ*COORD_W-1:0]            topLeftY_sel,
    output logic [NUM_OBJ*COORD_W-1:0]            width_sel,
    output logic [NUM_OBJ*COORD_W-1:0]            height_sel,
    output logic [NUM_OBJ*COLOR_W-1:0]            color_sel,
    output logic [NUM_OBJ-1:0]                    enable_sel
);

    // Gather every object of the chosen level into the output slice.
    always_comb begin
        topLeftX_sel = '0;
        topLeftY_sel = '0;
        width_sel    = '0;
        height_sel   = '0;
        color_sel    = '0;
        enable_sel   = '0;
        for (int unsigned o = 0; o < NUM_OBJ; o++) begin
            topLeftX_sel[lm_field_base(o, COORD_W) +: COORD_W] =
                topLeftX_in[lm_field_base(lm_obj_index(32'(level), o, NUM_OBJ), COORD_W) +: COORD_W];
            topLeftY_sel[lm_field_base(o, COORD_W) +: COORD_W] =
                topLeftY_in[lm_field_base(lm_obj_index(32'(level), o, NUM_OBJ), COORD_W) +: COORD_W];
            width_sel[lm_field_base(o, COORD_W) +: COORD_W] =
                width_in[lm_field_base(lm_obj_index(32'(level), o, NUM_OBJ), COORD_W) +: COORD_W];
            height_sel[lm_field_base(o, COORD_W) +: COORD_W] =
                height_in[lm_field_base(lm_obj_index(32'(level), o, NUM_OBJ), COORD_W) +: COORD_W];
            color_sel[lm_field_base(o, COLOR_W) +: COLOR_W] =
                color_in[lm_field_base(lm_obj_index(32'(level), o, NUM_OBJ), COLOR_W) +: COLOR_W];
            enable_sel[o] = enable_in[lm_obj_index(32'(level), o, NUM_OBJ)];
        end
    end

endmodule

// File: rtl/level_set_mux.sv
// Registered per-level object-set selector. Level switches are requested via
// valid/ready and applied on frame boundaries. Define LEVEL_MUX_BLANK_EN to
// add a blanking interval of BLANK_FRAMES frames with enables forced off.
module level_set_mux
    import level_mux_pkg::*;
#(
    parameter int unsigned  NUM_LEVELS   = DEF_NUM_LEVELS,
    parameter int unsigned  NUM_OBJ      = DEF_NUM_OBJ,
    parameter int unsigned  COORD_W      = DEF_COORD_W,
    parameter int unsigned  COLOR_W      = DEF_COLOR_W,
    parameter int unsigned  BLANK_FRAMES = DEF_BLANK_FRAMES,
    localparam int unsigned LW           = $clog2(NUM_LEVELS)
) (
    input  logic                                  clk,
    input  logic                                  resetN,
    input  logic                                  startOfFrame,
    input  logic [LW-1:0]                         levelCode,
    input  logic                                  levelReqValid,
    output logic                                  levelReqReady,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] topLeftX_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] topLeftY_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] width_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COORD_W-1:0] height_in,
    input  logic [NUM_LEVELS*NUM_OBJ*COLOR_W-1:0] color_in,
    input  logic [NUM_LEVELS*NUM_OBJ-1:0]         enable_in,
    output logic [NUM_OBJ*COORD_W-1:0]            topLeftX_out,
    output logic [NUM_OBJ*COORD_W-1:0]            topLeftY_out,
    output logic [NUM_OBJ*COORD_W-1:0]            width_out,
    output logic [NUM_OBJ*COORD_W-1:0]            height_out,
    output logic [NUM_OBJ*COLOR_W-1:0]            color_out,
    output logic [NUM_OBJ-1:0]                    enable_out,
    output logic [LW-1:0]                         activeLevel,
    output logic                                  switching,
    output logic                                  switchDone,
    output logic                                  badCode
);

    if (NUM_LEVELS < 2) begin : g_bad_levels
        $error("level_set_mux: NUM_LEVELS must be at least 2");
    end
    if (BLANK_FRAMES < 1) begin : g_bad_blank
        $error("level_set_mux: BLANK_FRAMES must be at least 1");
    end

    lm_state_t     state;
    logic [LW-1:0] next_level;

`ifdef LEVEL_MUX_BLANK_EN
    localparam int unsigned FW = $clog2(BLANK_FRAMES + 1);
    logic [FW-1:0] frame_cnt;
`endif

    logic                       req_accept;
    logic                       req_bad;
    logic                       switch_fire;
    logic                       load_data;
    logic [LW-1:0]              sel_level;
    logic [NUM_OBJ*COORD_W-1:0] sel_x, sel_y, sel_w, sel_h;
    logic [NUM_OBJ*COLOR_W-1:0] sel_color;
    logic [NUM_OBJ-1:0]         sel_enable;

    assign levelReqReady = (state == ACTIVE);
    assign switching     = (state != ACTIVE);

    // Decode acceptance, switch completion and whether the outputs reload.
    always_comb begin
        req_accept = levelReqValid && (state == ACTIVE);
        req_bad    = req_accept && (32'(levelCode) >= NUM_LEVELS);
`ifdef LEVEL_MUX_BLANK_EN
        switch_fire = (state == BLANK) && startOfFrame &&
                      (32'(frame_cnt) + 32'd1 == BLANK_FRAMES);
        // Outputs track the old level until blanking starts, then hold.
        load_data   = (state == ACTIVE) || switch_fire ||
                      ((state == PENDING) && !startOfFrame);
`else
        switch_fire = (state == PENDING) && startOfFrame;
        load_data   = 1'b1;
`endif
        // The completing edge already loads the new level's slice.
        sel_level = switch_fire ? next_level : activeLevel;
    end

    level_slice_sel #(
        .NUM_LEVELS (NUM_LEVELS),
        .NUM_OBJ    (NUM_OBJ),
        .COORD_W    (COORD_W),
        .COLOR_W    (COLOR_W)
    ) u_slice_sel (
        .level        (sel_level),
        .topLeftX_in  (topLeftX_in),
        .topLeftY_in  (topLeftY_in),
        .width_in     (width_in),
        .height_in    (height_in),
        .color_in     (color_in),
        .enable_in    (enable_in),
        .topLeftX_sel (sel_x),
        .topLeftY_sel (sel_y),
        .width_sel    (sel_w),
        .height_sel   (sel_h),
        .color_sel    (sel_color),
        .enable_sel   (sel_enable)
    );

    // Switch FSM with registered data outputs and status pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ACTIVE;
            next_level   <= '0;
            activeLevel  <= '0;
            switchDone   <= 1'b0;
            badCode      <= 1'b0;
            topLeftX_out <= '0;
            topLeftY_out <= '0;
            width_out    <= '0;
            height_out   <= '0;
            color_out    <= '0;
            enable_out   <= '0;
`ifdef LEVEL_MUX_BLANK_EN
            frame_cnt    <= '0;
`endif
        end else begin
            switchDone <= 1'b0;
            badCode    <= 1'b0;

            if (load_data) begin
                topLeftX_out <= sel_x;
                topLeftY_out <= sel_y;
                width_out    <= sel_w;
                height_out   <= sel_h;
                color_out    <= sel_color;
                enable_out   <= sel_enable;
            end else begin
                enable_out   <= '0;
            end

            case (state)
                ACTIVE: begin
                    if (req_accept) begin
                        if (req_bad) begin
                            badCode <= 1'b1;
                        end else if (levelCode == activeLevel) begin
                            switchDone <= 1'b1;
                        end else begin
                            next_level <= levelCode;
                            state      <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (startOfFrame) begin
`ifdef LEVEL_MUX_BLANK_EN
                        frame_cnt <= '0;
                        state     <= BLANK;
`else
                        activeLevel <= next_level;
                        switchDone  <= 1'b1;
                        state       <= ACTIVE;
`endif
                    end
                end
`ifdef LEVEL_MUX_BLANK_EN
                BLANK: begin
                    if (switch_fire) begin
                        activeLevel <= next_level;
                        switchDone  <= 1'b1;
                        state       <= ACTIVE;
                    end else if (startOfFrame) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
`endif
                default: state <= ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_level_set_mux.sv
// Self-checking bench for level_set_mux: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_level_set_mux;

    localparam int NL = 3;
    localparam int NO = 4;
    localparam int CW = 11;
    localparam int KW = 8;
    localparam int BF = 2;
    localparam int LW = 2;
`ifdef LEVEL_MUX_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam int NEED = BLANK_EN ? BF + 1 : 1;

    logic                  clk;
    logic                  resetN;
    logic                  sof;
    logic [LW-1:0]         code;
    logic                  valid;
    logic                  ready;
    logic [NL*NO*CW-1:0]   x_in, y_in, w_in, h_in;
    logic [NL*NO*KW-1:0]   c_in;
    logic [NL*NO-1:0]      e_in;
    logic [NO*CW-1:0]      x_out, y_out, w_out, h_out;
    logic [NO*KW-1:0]      c_out;
    logic [NO-1:0]         e_out;
    logic [LW-1:0]         act_lvl;
    logic                  sw, done, bad;

    // Model state
    int                    m_level;
    int                    m_target;
    int                    m_sofs;
    logic [NO*CW-1:0]      ex_x, ex_y, ex_w, ex_h;
    logic [NO*KW-1:0]      ex_c;
    logic [NO-1:0]         ex_e;
    logic                  ex_done, ex_bad;

    int                    total_cnt;
    int                    pass_cnt;
    int                    fail_cnt;

    level_set_mux #(
        .NUM_LEVELS   (NL),
        .NUM_OBJ      (NO),
        .COORD_W      (CW),
        .COLOR_W      (KW),
        .BLANK_FRAMES (BF)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (sof),
        .levelCode     (code),
        .levelReqValid (valid),
        .levelReqReady (ready),
        .topLeftX_in   (x_in),
        .topLeftY_in   (y_in),
        .width_in      (w_in),
        .height_in     (h_in),
        .color_in      (c_in),
        .enable_in     (e_in),
        .topLeftX_out  (x_out),
        .topLeftY_out  (y_out),
        .width_out     (w_out),
        .height_out    (h_out),
        .color_out     (c_out),
        .enable_out    (e_out),
        .activeLevel   (act_lvl),
        .switching     (sw),
        .switchDone    (done),
        .badCode       (bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NO*CW-1:0] pick_c(input logic [NL*NO*CW-1:0] v, input int lvl);
        logic [NO*CW-1:0] r;
        r = '0;
        for (int o = 0; o < NO; o++) r[o*CW +: CW] = v[(lvl*NO + o)*CW +: CW];
        return r;
    endfunction

    function automatic logic [NO*KW-1:0] pick_k(input logic [NL*NO*KW-1:0] v, input int lvl);
        logic [NO*KW-1:0] r;
        r = '0;
        for (int o = 0; o < NO; o++) r[o*KW +: KW] = v[(lvl*NO + o)*KW +: KW];
        return r;
    endfunction

    function automatic logic [NO-1:0] pick_e(input logic [NL*NO-1:0] v, input int lvl);
        logic [NO-1:0] r;
        r = '0;
        for (int o = 0; o < NO; o++) r[o] = v[lvl*NO + o];
        return r;
    endfunction

    task automatic new_data();
        for (int i = 0; i < NL*NO; i++) begin
            x_in[i*CW +: CW] = CW'($urandom);
            y_in[i*CW +: CW] = CW'($urandom);
            w_in[i*CW +: CW] = CW'($urandom);
            h_in[i*CW +: CW] = CW'($urandom);
            c_in[i*KW +: KW] = KW'($urandom);
            e_in[i]          = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic model_reset();
        m_level  = 0;
        m_target = -1;
        m_sofs   = 0;
        ex_x = '0; ex_y = '0; ex_w = '0; ex_h = '0; ex_c = '0; ex_e = '0;
        ex_done = 1'b0;
        ex_bad  = 1'b0;
    endtask

    task automatic model_load(input int lvl);
        ex_x = pick_c(x_in, lvl);
        ex_y = pick_c(y_in, lvl);
        ex_w = pick_c(w_in, lvl);
        ex_h = pick_c(h_in, lvl);
        ex_c = pick_k(c_in, lvl);
        ex_e = pick_e(e_in, lvl);
    endtask

    // Expected state after the coming clock edge, from the inputs now applied.
    task automatic model_step();
        ex_done = 1'b0;
        ex_bad  = 1'b0;
        if (!resetN) begin
            model_reset();
        end else if (m_target < 0) begin
            model_load(m_level);
            if (valid) begin
                if (int'(code) >= NL) ex_bad = 1'b1;
                else if (int'(code) == m_level) ex_done = 1'b1;
                else begin
                    m_target = int'(code);
                    m_sofs   = 0;
                end
            end
        end else begin
            if (sof) m_sofs++;
            if (m_sofs == NEED) begin
                m_level  = m_target;
                m_target = -1;
                model_load(m_level);
                ex_done  = 1'b1;
            end else if (BLANK_EN && m_sofs >= 1) begin
                ex_e = '0;
            end else begin
                model_load(m_level);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("topLeftX",    64'(x_out),   64'(ex_x));
        chk("topLeftY",    64'(y_out),   64'(ex_y));
        chk("width",       64'(w_out),   64'(ex_w));
        chk("height",      64'(h_out),   64'(ex_h));
        chk("color",       64'(c_out),   64'(ex_c));
        chk("enable",      64'(e_out),   64'(ex_e));
        chk("activeLevel", 64'(act_lvl), 64'(m_level));
        chk("ready",       64'(ready),   64'(m_target < 0));
        chk("switching",   64'(sw),      64'(m_target >= 0));
        chk("switchDone",  64'(done),    64'(ex_done));
        chk("badCode",     64'(bad),     64'(ex_bad));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        sof   = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_pulse();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic request(input int lvl);
        valid = 1'b1;
        code  = LW'(lvl);
        tick();
        valid = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        resetN = 1'b0;
        sof    = 1'b0;
        valid  = 1'b0;
        code   = '0;
        new_data();
        model_reset();

        // Reset held: outputs stay zero
        idle(3);
        resetN = 1'b1;
        idle(2);
        new_data();
        idle(2);

        // Mid-frame switch to level 2, data changing throughout
        request(2);
        idle(2);
        for (int f = 0; f < NEED + 1; f++) begin
            frame_pulse();
            new_data();
            idle(3);
        end

        // Out-of-range code is dropped
        request(3);
        idle(2);

        // Request the current level
        request(m_level);
        idle(2);

        // Request coincident with a frame pulse, then a second request while pending
        sof = 1'b1;
        request((m_level + 1) % NL);
        sof = 1'b0;
        idle(2);
        request((m_level + 2) % NL);
        idle(2);
        for (int f = 0; f < NEED + 1; f++) begin
            frame_pulse();
            idle(3);
        end

        // Reset mid-switch
        request((m_level + 1) % NL);
        idle(1);
        frame_pulse();
        idle(2);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        idle(2);
        resetN = 1'b1;
        idle(3);
        for (int f = 0; f < NEED + 1; f++) frame_pulse();
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) new_data();
            sof   = ($urandom_range(0, 5) == 0);
            valid = ($urandom_range(0, 6) == 0);
            code  = LW'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
